// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - write-port arbiter for the 8x16 config register file
//
// Purpose: shares the single config register-file write port between host byte
// writes (async strobe, synchronized, buffered in a small FIFO) and sweep
// override word writes. A stall counter bounds how long a queued host write can
// be held off by back-to-back overrides.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   host_strobe_raw    async host strobe; each rising edge requests one byte write
//   host_addr          [ADDR_BITS:1] word address, [0] byte select (1 = high byte)
//   host_data          host byte
//   ovr_req            override request (level, re-evaluated every cycle)
//   ovr_addr/ovr_data  override word address / word
//   ovr_ack            combinational override grant for this cycle
//   cfg_we             registered byte enables {hi, lo}
//   cfg_w_addr/data    registered write address / data
//   fifo_level         host FIFO occupancy
//   overflow           sticky: a host write was dropped
//   drop_count         saturating count of dropped host writes
//                      (present only when CFG_ARB_DROP_COUNT_EN is defined)
//
// Build option: CFG_ARB_DROP_COUNT_EN
module cfg_write_arbiter #(
  parameter int ADDR_BITS       = 3,
  parameter int DATA_BITS       = 16,
  parameter int LOG2_FIFO_DEPTH = 2,
  parameter int MAX_STALL       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_strobe_raw,
  input  logic [ADDR_BITS:0]         host_addr,
  input  logic [7:0]                 host_data,
  input  logic                       ovr_req,
  input  logic [ADDR_BITS-1:0]       ovr_addr,
  input  logic [DATA_BITS-1:0]       ovr_data,
  output logic                       ovr_ack,
  output logic [1:0]                 cfg_we,
  output logic [ADDR_BITS-1:0]       cfg_w_addr,
  output logic [DATA_BITS-1:0]       cfg_w_data,
  output logic [LOG2_FIFO_DEPTH:0]   fifo_level,
  output logic                       overflow
`ifdef CFG_ARB_DROP_COUNT_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int DEPTH   = 1 << LOG2_FIFO_DEPTH;
  localparam int ENTRY_W = ADDR_BITS + 1 + 8;
  localparam int STALL_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  logic                       r_s1;
  logic                       r_s2;
  logic                       r_prev;
  logic [ENTRY_W-1:0]         r_mem [DEPTH];
  logic [LOG2_FIFO_DEPTH:0]   r_wptr;
  logic [LOG2_FIFO_DEPTH:0]   r_rptr;
  logic [STALL_W-1:0]         r_stall;
  logic [1:0]                 r_we;
  logic [ADDR_BITS-1:0]       r_addr;
  logic [DATA_BITS-1:0]       r_data;
  logic                       r_overflow;

  logic                       w_edge;
  logic [LOG2_FIFO_DEPTH:0]   w_level;
  logic                       w_nonempty;
  logic                       w_full;
  logic                       w_grant_ovr;
  logic                       w_grant_host;
  logic                       w_push;
  logic                       w_drop;
  logic [ENTRY_W-1:0]         w_head;

  assign w_edge     = r_s2 & ~r_prev;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level    = r_wptr - r_rptr;
  assign w_nonempty = (w_level != '0);
  assign w_full     = (w_level == (LOG2_FIFO_DEPTH+1)'(DEPTH));
  assign w_head     = r_mem[r_rptr[LOG2_FIFO_DEPTH-1:0]];

  assign w_grant_ovr  = ovr_req & (~w_nonempty | (r_stall < STALL_MAX));
  assign w_grant_host = w_nonempty & ~w_grant_ovr;

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_push = w_edge & (~w_full | w_grant_host);
  assign w_drop = w_edge & w_full & ~w_grant_host;

  assign ovr_ack    = w_grant_ovr & rst_n;
  assign cfg_we     = r_we;
  assign cfg_w_addr = r_addr;
  assign cfg_w_data = r_data;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;

  // Storage needs no reset: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[LOG2_FIFO_DEPTH-1:0]] <= {host_addr, host_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_prev     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_stall    <= '0;
      r_we       <= 2'b00;
      r_addr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1   <= host_strobe_raw;
      r_s2   <= r_s1;
      r_prev <= r_s2;

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_grant_host) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (w_grant_host || !w_nonempty) begin
        r_stall <= '0;
      end else if (w_grant_ovr && (r_stall != STALL_MAX)) begin
        r_stall <= r_stall + STALL_W'(1);
      end

      if (w_grant_ovr) begin
        r_we   <= 2'b11;
        r_addr <= ovr_addr;
        r_data <= ovr_data;
      end else if (w_grant_host) begin
        r_we   <= w_head[8] ? 2'b10 : 2'b01;
        r_addr <= w_head[ENTRY_W-1:9];
        r_data <= DATA_BITS'({2{w_head[7:0]}});
      end else begin
        r_we <= 2'b00;
      end
    end
  end

`ifdef CFG_ARB_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - self-checking bench for cfg_write_arbiter
module tb_cfg_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Primary DUT (default parameters)
  logic        rst_n, strobe, ovr_req;
  logic [3:0]  h_addr;
  logic [7:0]  h_data;
  logic [2:0]  ovr_addr;
  logic [15:0] ovr_data;
  logic        ovr_ack;
  logic [1:0]  cfg_we;
  logic [2:0]  cfg_w_addr;
  logic [15:0] cfg_w_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  // Second DUT with the stall guard effectively disabled
  logic        rst2_n, strobe2, ovr_req2;
  logic [3:0]  h_addr2;
  logic [7:0]  h_data2;
  logic        ovr_ack2;
  logic [1:0]  cfg_we2;
  logic [2:0]  cfg_w_addr2;
  logic [15:0] cfg_w_data2;
  logic [2:0]  fifo_level2;
  logic        overflow2;

`ifdef CFG_ARB_DROP_COUNT_EN
  logic [7:0]  drop_count;
  logic [7:0]  drop_count2;
`endif

  cfg_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .host_strobe_raw(strobe),
    .host_addr(h_addr), .host_data(h_data),
    .ovr_req(ovr_req), .ovr_addr(ovr_addr), .ovr_data(ovr_data),
    .ovr_ack(ovr_ack), .cfg_we(cfg_we), .cfg_w_addr(cfg_w_addr),
    .cfg_w_data(cfg_w_data), .fifo_level(fifo_level), .overflow(overflow)
`ifdef CFG_ARB_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  cfg_write_arbiter #(.MAX_STALL(255)) dut2 (
    .clk(clk), .rst_n(rst2_n), .host_strobe_raw(strobe2),
    .host_addr(h_addr2), .host_data(h_data2),
    .ovr_req(ovr_req2), .ovr_addr(3'd6), .ovr_data(16'hBEEF),
    .ovr_ack(ovr_ack2), .cfg_we(cfg_we2), .cfg_w_addr(cfg_w_addr2),
    .cfg_w_data(cfg_w_data2), .fifo_level(fifo_level2), .overflow(overflow2)
`ifdef CFG_ARB_DROP_COUNT_EN
    , .drop_count(drop_count2)
`endif
  );

  int test_cnt = 0;
  int err_cnt  = 0;
  logic [20:0] sb[$];   // {we, addr, data}
  int seq;
  bit exp_ack [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write the primary DUT commits must match the queue head.
  always @(negedge clk) begin
    if (cfg_we != 2'b00) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_we", {30'd0, cfg_we}, 32'd0);
      end else begin
        check("sb_write", {11'd0, cfg_we, cfg_w_addr, cfg_w_data}, {11'd0, sb.pop_front()});
      end
    end
  end

  task automatic pulse2(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    h_addr2 = a; h_data2 = d; strobe2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 strobe2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    strobe = 1'b0; strobe2 = 1'b0;
    h_addr = '0; h_data = '0; h_addr2 = '0; h_data2 = '0;
    ovr_req = 1'b1; ovr_addr = '0; ovr_data = '0;
    ovr_req2 = 1'b1;

    // Reset state (override requested during reset must not be acked)
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we",    {30'd0, cfg_we}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    check("rst_ack",   {31'd0, ovr_ack}, 32'd0);
    ovr_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rst2_n = 1'b1;

    // Single host write: high byte of word 2, lands at edge 4
    @(posedge clk); #1;
    h_addr = 4'b0101; h_data = 8'hA5; strobe = 1'b1;
    sb.push_back({2'b10, 3'd2, 16'hA5A5});
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("host_lat_e%0d", e), {30'd0, cfg_we}, (e == 4) ? 32'd2 : 32'd0);
      if (e == 3) check("host_lvl_pushed", {29'd0, fifo_level}, 32'd1);
      if (e == 4) begin
        check("host_addr", {29'd0, cfg_w_addr}, 32'd2);
        check("host_data", {16'd0, cfg_w_data}, 32'hA5A5);
        check("host_lvl_popped", {29'd0, fifo_level}, 32'd0);
      end
    end
    strobe = 1'b0;

    // Override only
    @(posedge clk); #1;
    ovr_req = 1'b1; ovr_addr = 3'd3; ovr_data = 16'h1234;
    sb.push_back({2'b11, 3'd3, 16'h1234});
    @(negedge clk);
    check("ovr_ack_same_cycle", {31'd0, ovr_ack}, 32'd1);
    @(posedge clk); #1;
    ovr_req = 1'b0;
    @(negedge clk);
    check("ovr_we",   {30'd0, cfg_we}, 32'd3);
    check("ovr_addr", {29'd0, cfg_w_addr}, 32'd3);
    check("ovr_data", {16'd0, cfg_w_data}, 32'h1234);
    check("ovr_idle_ack", {31'd0, ovr_ack}, 32'd0);

    // Starvation guard: overrides held, one host byte queued at edge 3
    @(posedge clk); #1;
    seq = 0;
    ovr_req = 1'b1; ovr_addr = 3'd1;
    h_addr = 4'b0111; h_data = 8'h5C; strobe = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ovr_data = 16'h1000 + 16'(seq);
      @(negedge clk);
      check($sformatf("starve_ack_c%0d", k), {31'd0, ovr_ack}, {31'd0, exp_ack[k]});
      if (exp_ack[k]) begin
        sb.push_back({2'b11, 3'd1, 16'h1000 + 16'(seq)});
        seq++;
      end else begin
        sb.push_back({2'b10, 3'd3, 16'h5C5C});
      end
      if (k == 3) strobe = 1'b0;
      @(posedge clk); #1;
    end
    ovr_req = 1'b0;

    // Async reset in the cycle a low-byte write is presented
    @(posedge clk); #1;
    h_addr = 4'b1000; h_data = 8'h3C; strobe = 1'b1;
    sb.push_back({2'b01, 3'd4, 16'h3C3C});
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 3) strobe = 1'b0;
    end
    check("rstmid_we_before", {30'd0, cfg_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_we",    {30'd0, cfg_we}, 32'd0);
    check("rstmid_level", {29'd0, fifo_level}, 32'd0);
    check("rstmid_ovf",   {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstmid_no_stale", {30'd0, cfg_we}, 32'd0);
    end
    @(posedge clk); #1;
    h_addr = 4'b1001; h_data = 8'h77; strobe = 1'b1;
    sb.push_back({2'b10, 3'd4, 16'h7777});
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 3) strobe = 1'b0;
    end
    check("rstmid_new_edge_we", {30'd0, cfg_we}, 32'd2);

    // Overflow on dut2: overrides never yield, so the FIFO fills
    for (int i = 0; i < 4; i++) begin
      pulse2(4'(i), 8'(8'h20 + i));
      check($sformatf("fill_lvl_%0d", i), {29'd0, fifo_level2}, 32'(i + 1));
    end
    check("fill_ovf_clear", {31'd0, overflow2}, 32'd0);
    check("fill_ovr_ack",   {31'd0, ovr_ack2}, 32'd1);
    pulse2(4'b1111, 8'hFF);
    check("ovf_level", {29'd0, fifo_level2}, 32'd4);
    check("ovf_flag",  {31'd0, overflow2}, 32'd1);
`ifdef CFG_ARB_DROP_COUNT_EN
    check("ovf_drop_count", {24'd0, drop_count2}, 32'd1);
`endif

    // Reset discards FIFO contents and the sticky flag
    #1 rst2_n = 1'b0;
    #1;
    check("rst2_level", {29'd0, fifo_level2}, 32'd0);
    check("rst2_ovf",   {31'd0, overflow2}, 32'd0);
`ifdef CFG_ARB_DROP_COUNT_EN
    check("rst2_drop_count", {24'd0, drop_count2}, 32'd0);
`endif
    @(posedge clk); #1;
    rst2_n = 1'b1;

    // Refill, then coincide a host pop with a push while full
    pulse2(4'b0011, 8'h11);
    pulse2(4'b0100, 8'h22);
    pulse2(4'b0110, 8'h33);
    pulse2(4'b1000, 8'h44);
    check("refill_lvl", {29'd0, fifo_level2}, 32'd4);
    @(posedge clk); #1;
    h_addr2 = 4'b1110; h_data2 = 8'hEE; strobe2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ovr_req2 = 1'b0; strobe2 = 1'b0;
    @(negedge clk);
    check("pp_ack_denied", {31'd0, ovr_ack2}, 32'd0);
    @(posedge clk); #1;
    ovr_req2 = 1'b1;
    @(negedge clk);
    check("pp_level", {29'd0, fifo_level2}, 32'd4);
    check("pp_ovf",   {31'd0, overflow2}, 32'd0);
    check("pp_we",    {30'd0, cfg_we2}, 32'd2);
    check("pp_addr",  {29'd0, cfg_w_addr2}, 32'd1);
    check("pp_data",  {16'd0, cfg_w_data2}, 32'h1111);

    // Every expected primary-DUT write must have been seen
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, err_cnt);
    $finish;
  end

endmodule
